// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: memory-op codes, FSM states and
// small decode helpers used by the stage and by the alignment unit.
package mem_access_pkg;

  localparam int WORD_WIDTH    = 32;
  localparam int MEMOP_WIDTH   = 4;
  localparam int BYTE_EN_WIDTH = 4;

  localparam logic [MEMOP_WIDTH-1:0] MEM_NONE = 4'd0;
  localparam logic [MEMOP_WIDTH-1:0] MEM_LB   = 4'd1;
  localparam logic [MEMOP_WIDTH-1:0] MEM_LBU  = 4'd2;
  localparam logic [MEMOP_WIDTH-1:0] MEM_LH   = 4'd3;
  localparam logic [MEMOP_WIDTH-1:0] MEM_LHU  = 4'd4;
  localparam logic [MEMOP_WIDTH-1:0] MEM_LW   = 4'd5;
  localparam logic [MEMOP_WIDTH-1:0] MEM_SB   = 4'd6;
  localparam logic [MEMOP_WIDTH-1:0] MEM_SH   = 4'd7;
  localparam logic [MEMOP_WIDTH-1:0] MEM_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

  // Any code outside LB..SW is a plain pass-through.
  function automatic logic is_mem(input logic [MEMOP_WIDTH-1:0] op);
    return (op >= MEM_LB) && (op <= MEM_SW);
  endfunction

  function automatic logic is_store(input logic [MEMOP_WIDTH-1:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic misaligned(input logic [MEMOP_WIDTH-1:0] op,
                                      input logic [1:0] lane);
    logic r;
    r = 1'b0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: r = lane[0];
      MEM_LW, MEM_SW:          r = |lane;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational byte-lane alignment for 32-bit little-endian memory.
//   i_op     : memory op code
//   i_lane   : addr[1:0]
//   i_sdata  : store data (rt)
//   i_rdata  : raw bus read word
//   o_be     : store byte enables (0 for loads / none)
//   o_wdata  : lane-replicated store data
//   o_ldata  : extracted, sign/zero-extended load value
module mem_align
  import mem_access_pkg::*;
(
  input  logic [MEMOP_WIDTH-1:0]   i_op,
  input  logic [1:0]               i_lane,
  input  logic [WORD_WIDTH-1:0]    i_sdata,
  input  logic [WORD_WIDTH-1:0]    i_rdata,
  output logic [BYTE_EN_WIDTH-1:0] o_be,
  output logic [WORD_WIDTH-1:0]    o_wdata,
  output logic [WORD_WIDTH-1:0]    o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Replicating store data across lanes lets the memory pick any lane
  // purely by byte enables.
  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    case (i_op)
      MEM_SB: begin
        o_be    = 4'b0001 << i_lane;
        o_wdata = {4{i_sdata[7:0]}};
      end
      MEM_SH: begin
        o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_sdata[15:0]}};
      end
      MEM_SW: begin
        o_be    = 4'hF;
        o_wdata = i_sdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ldata = '0;
    case (i_op)
      MEM_LB:  o_ldata = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: o_ldata = {24'd0, w_byte};
      MEM_LH:  o_ldata = {{16{w_half[15]}}, w_half};
      MEM_LHU: o_ldata = {16'd0, w_half};
      MEM_LW:  o_ldata = i_rdata;
      default: o_ldata = '0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage. Takes the EX result as address (or pass-through
// value), runs loads/stores over a req/ack bus, and emits a one-cycle
// write-back payload. Misaligned accesses and bus timeouts are flagged
// with one-cycle pulses and produce no write-back.
//   clk/rst                  : clock, synchronous active-high reset
//   in_valid/in_ready        : EX handshake (in_ready low only while on bus)
//   mem_op/addr/store_data   : op, ALU result, rt
//   wb_reg/wb_en_in          : destination register and its write enable
//   out_valid/out_data/out_reg/out_wen : write-back payload
//   addr_err/bus_err         : misalignment / timeout pulses
//   bus_*                    : word-aligned req/ack data bus
module mem_access
  import mem_access_pkg::*;
#(
  parameter int W           = WORD_WIDTH,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MEMOP_WIDTH-1:0]   mem_op,
  input  logic [W-1:0]             addr,
  input  logic [W-1:0]             store_data,
  input  logic [4:0]               wb_reg,
  input  logic                     wb_en_in,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic [4:0]               out_reg,
  output logic                     out_wen,
  output logic                     addr_err,
  output logic                     bus_err,
  output logic                     bus_req,
  output logic                     bus_we,
  output logic [W-1:0]             bus_addr,
  output logic [BYTE_EN_WIDTH-1:0] bus_be,
  output logic [W-1:0]             bus_wdata,
  input  logic                     bus_ack,
  input  logic [W-1:0]             bus_rdata
);

  localparam int CW = $clog2(BUS_TIMEOUT + 1);

  mem_state_t             r_state;
  logic [CW-1:0]          r_cnt;
  logic [MEMOP_WIDTH-1:0] r_op;
  logic [1:0]             r_lane;
  logic [4:0]             r_reg;
  logic                   r_wen;

  logic [MEMOP_WIDTH-1:0]   w_op;
  logic [MEMOP_WIDTH-1:0]   w_al_op;
  logic [1:0]               w_al_lane;
  logic [BYTE_EN_WIDTH-1:0] w_be;
  logic [W-1:0]             w_wdata;
  logic [W-1:0]             w_ldata;

  assign in_ready = (r_state != ST_BUS);
  assign w_op     = is_mem(mem_op) ? mem_op : MEM_NONE;

  // One aligner serves both phases: while on the bus it sees the latched
  // op (load extract); otherwise it sees the incoming op (store setup).
  assign w_al_op   = (r_state == ST_BUS) ? r_op   : w_op;
  assign w_al_lane = (r_state == ST_BUS) ? r_lane : addr[1:0];

  mem_align u_align (
    .i_op    (w_al_op),
    .i_lane  (w_al_lane),
    .i_sdata (store_data),
    .i_rdata (bus_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_ldata (w_ldata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_op      <= MEM_NONE;
      r_lane    <= '0;
      r_reg     <= '0;
      r_wen     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_reg   <= '0;
      out_wen   <= 1'b0;
      addr_err  <= 1'b0;
      bus_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      out_valid <= 1'b0;
      out_wen   <= 1'b0;
      addr_err  <= 1'b0;
      bus_err   <= 1'b0;
      case (r_state)
        ST_BUS: begin
          if (bus_ack) begin
            bus_req   <= 1'b0;
            out_valid <= 1'b1;
            out_reg   <= r_reg;
            if (is_store(r_op)) begin
              out_data <= '0;
              out_wen  <= 1'b0;
            end else begin
              out_data <= w_ldata;
              out_wen  <= r_wen;
            end
            r_state <= ST_DONE;
          end else if (r_cnt == CW'(BUS_TIMEOUT - 1)) begin
            bus_err <= 1'b1;
            bus_req <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin  // IDLE or DONE: both accept
          r_state <= ST_IDLE;
          if (in_valid) begin
            if (w_op == MEM_NONE) begin
              out_valid <= 1'b1;
              out_data  <= addr;
              out_reg   <= wb_reg;
              out_wen   <= wb_en_in;
              r_state   <= ST_DONE;
            end else if (misaligned(w_op, addr[1:0])) begin
              addr_err <= 1'b1;
            end else begin
              r_op      <= w_op;
              r_lane    <= addr[1:0];
              r_reg     <= wb_reg;
              r_wen     <= wb_en_in;
              r_cnt     <= '0;
              bus_req   <= 1'b1;
              bus_we    <= is_store(w_op);
              bus_addr  <= {addr[W-1:2], 2'b00};
              bus_be    <= w_be;
              bus_wdata <= w_wdata;
              r_state   <= ST_BUS;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  mem_op = MEM_NONE;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  wb_reg = '0;
  logic        wb_en_in = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_reg;
  logic        out_wen;
  logic        addr_err;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access #(.W(32), .BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_op(mem_op), .addr(addr), .store_data(store_data),
    .wb_reg(wb_reg), .wb_en_in(wb_en_in),
    .out_valid(out_valid), .out_data(out_data), .out_reg(out_reg),
    .out_wen(out_wen), .addr_err(addr_err), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // kind: 0 pass-through, 1 bus op, 2 misaligned
  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  rg;
    logic        wen;
    int          kind;
    int          dly;
    logic [31:0] exp_data;
    logic        exp_wen;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NV = 14;
  vec_t vt[NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rg, input logic we);
    in_valid = 1'b1; mem_op = op; addr = a; store_data = sd; wb_reg = rg; wb_en_in = we;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{MEM_NONE, 32'h1234,  32'h0,         32'h0,         5'd5,  1'b1, 0, 0, 32'h1234,      1'b1, 32'h0,   4'h0,    32'h0};
    vt[1]  = '{MEM_SB,   32'h103,   32'hAB,        32'h0,         5'd6,  1'b1, 1, 0, 32'h0,         1'b0, 32'h100, 4'b1000, 32'hABABABAB};
    vt[2]  = '{MEM_LB,   32'h102,   32'h0,         32'h0080_0000, 5'd7,  1'b1, 1, 0, 32'hFFFF_FF80, 1'b1, 32'h100, 4'h0,    32'h0};
    vt[3]  = '{MEM_LBU,  32'h102,   32'h0,         32'h0080_0000, 5'd8,  1'b1, 1, 1, 32'h0000_0080, 1'b1, 32'h100, 4'h0,    32'h0};
    vt[4]  = '{MEM_LW,   32'h102,   32'h0,         32'h0,         5'd9,  1'b1, 2, 0, 32'h0,         1'b0, 32'h0,   4'h0,    32'h0};
    vt[5]  = '{MEM_LH,   32'h102,   32'h0,         32'h8001_1234, 5'd10, 1'b1, 1, 0, 32'hFFFF_8001, 1'b1, 32'h100, 4'h0,    32'h0};
    vt[6]  = '{MEM_LHU,  32'h100,   32'h0,         32'h8001_F234, 5'd11, 1'b1, 1, 0, 32'h0000_F234, 1'b1, 32'h100, 4'h0,    32'h0};
    vt[7]  = '{MEM_LW,   32'h104,   32'h0,         32'hDEAD_BEEF, 5'd12, 1'b1, 1, 2, 32'hDEAD_BEEF, 1'b1, 32'h104, 4'h0,    32'h0};
    vt[8]  = '{MEM_SH,   32'h102,   32'h1234_5678, 32'h0,         5'd13, 1'b0, 1, 0, 32'h0,         1'b0, 32'h100, 4'b1100, 32'h5678_5678};
    vt[9]  = '{MEM_SW,   32'h108,   32'hCAFE_F00D, 32'h0,         5'd14, 1'b0, 1, 1, 32'h0,         1'b0, 32'h108, 4'hF,    32'hCAFE_F00D};
    vt[10] = '{MEM_SH,   32'h101,   32'h1,         32'h0,         5'd15, 1'b0, 2, 0, 32'h0,         1'b0, 32'h0,   4'h0,    32'h0};
    vt[11] = '{4'hF,     32'h55,    32'h0,         32'h0,         5'd16, 1'b0, 0, 0, 32'h55,        1'b0, 32'h0,   4'h0,    32'h0};
    vt[12] = '{MEM_LB,   32'h101,   32'h0,         32'h0000_7F00, 5'd17, 1'b1, 1, 0, 32'h0000_007F, 1'b1, 32'h100, 4'h0,    32'h0};
    vt[13] = '{MEM_SB,   32'h100,   32'h1234_5680, 32'h0,         5'd18, 1'b1, 1, 0, 32'h0,         1'b0, 32'h100, 4'b0001, 32'h8080_8080};

    // Reset state
    step(); step();
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst bus_addr", bus_addr, 32'd0);
    chk("rst bus_be", {28'd0, bus_be}, 32'd0);
    rst = 1'b0;
    step();

    // Table-driven single transactions
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].op, vt[i].addr, vt[i].sdata, vt[i].rg, vt[i].wen);
      step();
      in_valid = 1'b0;
      if (vt[i].kind == 2) begin
        chk($sformatf("v%0d addr_err", i), {31'd0, addr_err}, 32'd1);
        chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd0);
        chk($sformatf("v%0d bus_req", i), {31'd0, bus_req}, 32'd0);
      end else if (vt[i].kind == 0) begin
        chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
        chk($sformatf("v%0d out_data", i), out_data, vt[i].exp_data);
        chk($sformatf("v%0d out_wen", i), {31'd0, out_wen}, {31'd0, vt[i].exp_wen});
        chk($sformatf("v%0d out_reg", i), {27'd0, out_reg}, {27'd0, vt[i].rg});
        chk($sformatf("v%0d bus_req", i), {31'd0, bus_req}, 32'd0);
      end else begin
        chk($sformatf("v%0d bus_req", i), {31'd0, bus_req}, 32'd1);
        chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd0);
        chk($sformatf("v%0d bus_addr", i), bus_addr, vt[i].exp_baddr);
        chk($sformatf("v%0d bus_we", i), {31'd0, bus_we}, {31'd0, (vt[i].exp_be != 4'h0)});
        if (vt[i].exp_be != 4'h0) begin
          chk($sformatf("v%0d bus_be", i), {28'd0, bus_be}, {28'd0, vt[i].exp_be});
          chk($sformatf("v%0d bus_wdata", i), bus_wdata, vt[i].exp_wdata);
        end
        for (int d = 0; d < vt[i].dly; d++) begin
          step();
          chk($sformatf("v%0d hold bus_req", i), {31'd0, bus_req}, 32'd1);
          chk($sformatf("v%0d hold bus_addr", i), bus_addr, vt[i].exp_baddr);
        end
        bus_ack = 1'b1; bus_rdata = vt[i].rdata;
        step();
        bus_ack = 1'b0;
        chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
        chk($sformatf("v%0d out_data", i), out_data, vt[i].exp_data);
        chk($sformatf("v%0d out_wen", i), {31'd0, out_wen}, {31'd0, vt[i].exp_wen});
        chk($sformatf("v%0d out_reg", i), {27'd0, out_reg}, {27'd0, vt[i].rg});
        chk($sformatf("v%0d bus_req low", i), {31'd0, bus_req}, 32'd0);
      end
      step();
      chk($sformatf("v%0d pulse end", i), {30'd0, out_valid, addr_err}, 32'd0);
    end

    // Timeout: 4 BUS cycles without ack
    drive(MEM_LW, 32'h200, 32'h0, 5'd3, 1'b1);
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("to still waiting", {29'd0, bus_req, bus_err, in_ready}, 32'b100);
    step();
    chk("to bus_err", {31'd0, bus_err}, 32'd1);
    chk("to bus_req", {31'd0, bus_req}, 32'd0);
    chk("to in_ready", {31'd0, in_ready}, 32'd1);
    chk("to out_valid", {31'd0, out_valid}, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h5A5A5A5A;
    step();
    bus_ack = 1'b0;
    chk("to err one cycle", {31'd0, bus_err}, 32'd0);
    step();
    chk("stray ack ignored", {30'd0, out_valid, bus_req}, 32'd0);

    // Back-to-back loads, second accepted while in DONE
    drive(MEM_LW, 32'h300, 32'h0, 5'd20, 1'b1);
    step();
    drive(MEM_LW, 32'h304, 32'h0, 5'd21, 1'b1);
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    step();
    bus_ack = 1'b0;
    chk("b2b first valid", {31'd0, out_valid}, 32'd1);
    chk("b2b first data", out_data, 32'h1111_1111);
    chk("b2b ready in DONE", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("b2b second req", {31'd0, bus_req}, 32'd1);
    chk("b2b second addr", bus_addr, 32'h304);
    chk("b2b gap valid", {31'd0, out_valid}, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h2222_2222;
    step();
    bus_ack = 1'b0;
    chk("b2b second valid", {31'd0, out_valid}, 32'd1);
    chk("b2b second data", out_data, 32'h2222_2222);
    chk("b2b second reg", {27'd0, out_reg}, 32'd21);
    step();

    // Reset while on the bus
    drive(MEM_LW, 32'h400, 32'h0, 5'd22, 1'b1);
    step();
    in_valid = 1'b0;
    chk("rb bus_req", {31'd0, bus_req}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rb req dropped", {31'd0, bus_req}, 32'd0);
    chk("rb in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("rb quiet %0d", k), {29'd0, out_valid, bus_err, bus_req}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
